// File: rtl/mul_add_pkg.sv
// Shared constants and types for the pipelined MonPro multiply-add datapath.
// The result is split into a high carry word and a low sum word.
package mul_add_pkg;

  localparam int unsigned DefaultW    = 64;
  localparam int unsigned MaxStages   = 8;
  localparam int unsigned DefaultResW = 2 * DefaultW;

  typedef struct packed {
    logic [DefaultW-1:0] c;
    logic [DefaultW-1:0] s;
  } res_t;

  // The multiplier is split into a low and a high slice of y; this gives the low slice width.
  function automatic int unsigned lo_width(int unsigned w);
    return w / 2;
  endfunction

endpackage

// File: rtl/mul_add_stage.sv
// One pipeline register stage: a valid bit, a data word and a sideband tag.
// The stage freezes whenever the global advance enable is low.
module mul_add_stage
  import mul_add_pkg::*;
#(
  parameter int unsigned DataW = DefaultResW,
  parameter int unsigned TagW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [DataW-1:0] i_data,
  input  logic [TagW-1:0]  i_tag,
  output logic             o_valid,
  output logic [DataW-1:0] o_data,
  output logic [TagW-1:0]  o_tag
);

  logic             r_valid;
  logic [DataW-1:0] r_data;
  logic [TagW-1:0]  r_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      // Bubbles leave the payload untouched to avoid needless toggling.
      if (i_valid) begin
        r_data <= i_data;
        r_tag  <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_tag   = r_tag;

endmodule

// File: rtl/mul_add_pipe.sv
// Pipelined {c,s} = x*y + z + carry with valid/ready on both sides and an optional
// carry-chain mode that feeds the last delivered high word back as the carry operand.
module mul_add_pipe
  import mul_add_pkg::*;
#(
  parameter int unsigned W      = DefaultW,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic [W-1:0]     in_z,
  input  logic [W-1:0]     in_c,
  input  logic             in_chain,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_s,
  output logic [W-1:0]     out_c,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned RW   = 2 * W;
  localparam int unsigned WLo  = lo_width(W);
  localparam int unsigned WHi  = W - WLo;
  localparam int unsigned PLoW = W + WLo;
  localparam int unsigned PHiW = W + WHi;
  localparam int unsigned AddW = W + 1;
  localparam int unsigned PPW  = PLoW + PHiW + AddW;

  logic [W-1:0]     r_c_hold;
  logic [W-1:0]     w_carry;
  logic             w_en;
  logic             w_acc;
  logic             w_deq;
  logic             w_busy;
  logic             w_last_valid;
  logic [RW-1:0]    w_last_data;
  logic [TAG_W-1:0] w_last_tag;
  logic [STAGES-1:0] w_vld;

  // Whole pipe advances together; a stalled output freezes every stage.
  assign w_en     = !w_last_valid || out_ready;
  assign w_busy   = |w_vld;
  assign in_ready = rst_n && w_en && !(in_chain && w_busy);
  assign w_acc    = in_valid && in_ready;
  assign w_deq    = w_last_valid && out_ready;
  assign w_carry  = in_chain ? r_c_hold : in_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_hold <= '0;
    end else if (w_deq) begin
      r_c_hold <= w_last_data[RW-1:W];
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      logic [RW-1:0] w_full;

      assign w_full = RW'(in_x) * RW'(in_y) + RW'(in_z) + RW'(w_carry);

      mul_add_stage #(
        .DataW (RW),
        .TagW  (TAG_W)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_valid (w_acc),
        .i_data  (w_full),
        .i_tag   (in_tag),
        .o_valid (w_vld[0]),
        .o_data  (w_last_data),
        .o_tag   (w_last_tag)
      );
    end else begin : g_multi
      logic [PPW-1:0]   w_pp_in;
      logic [PPW-1:0]   w_pp;
      logic [PLoW-1:0]  w_plo;
      logic [PHiW-1:0]  w_phi;
      logic [AddW-1:0]  w_add;
      logic [RW-1:0]    w_sum;
      logic [TAG_W-1:0] w_tag [STAGES];
      logic [RW-1:0]    w_dat [1:STAGES-1];

      // First stage holds two partial products (y split in halves) and the folded addends.
      assign w_pp_in = {PLoW'(in_x) * PLoW'(in_y[WLo-1:0]),
                        PHiW'(in_x) * PHiW'(in_y[W-1:WLo]),
                        AddW'(in_z) + AddW'(w_carry)};

      mul_add_stage #(
        .DataW (PPW),
        .TagW  (TAG_W)
      ) u_pp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_valid (w_acc),
        .i_data  (w_pp_in),
        .i_tag   (in_tag),
        .o_valid (w_vld[0]),
        .o_data  (w_pp),
        .o_tag   (w_tag[0])
      );

      assign {w_plo, w_phi, w_add} = w_pp;
      assign w_sum = RW'(w_plo) + (RW'(w_phi) << WLo) + RW'(w_add);

      for (genvar i = 1; i < STAGES; i++) begin : g_tail
        logic [RW-1:0] w_din;

        if (i == 1) begin : g_from_pp
          assign w_din = w_sum;
        end else begin : g_from_prev
          assign w_din = w_dat[i-1];
        end

        mul_add_stage #(
          .DataW (RW),
          .TagW  (TAG_W)
        ) u_stage (
          .clk     (clk),
          .rst_n   (rst_n),
          .i_en    (w_en),
          .i_valid (w_vld[i-1]),
          .i_data  (w_din),
          .i_tag   (w_tag[i-1]),
          .o_valid (w_vld[i]),
          .o_data  (w_dat[i]),
          .o_tag   (w_tag[i])
        );
      end

      assign w_last_data = w_dat[STAGES-1];
      assign w_last_tag  = w_tag[STAGES-1];
    end
  endgenerate

  assign w_last_valid = w_vld[STAGES-1];
  assign out_valid    = w_last_valid;
  assign out_s        = w_last_data[W-1:0];
  assign out_c        = w_last_data[RW-1:W];
  assign out_tag      = w_last_tag;
  assign busy         = w_busy;

endmodule

// File: tb/tb_mul_add_pipe.sv
// Bench for mul_add_pipe: directed steps on a W=64/STAGES=3 instance plus random traffic
// on W=32 instances with STAGES=1 and STAGES=8, all checked against a queue-based model.
module tb_mul_add_pipe;
  import mul_add_pkg::*;

  typedef struct {
    res_t       r;
    logic [7:0] tag;
    int         k;
    int         snap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [63:0] x [3];
  logic [63:0] y [3];
  logic [63:0] z [3];
  logic [63:0] cc [3];
  logic        vld [3];
  logic        chn [3];
  logic        ordy [3];
  logic [7:0]  tg [3];

  wire [2:0]  rdy, ovld, bsy;
  wire [63:0] os0, oc0;
  wire [31:0] os1, oc1, os2, oc2;
  wire [7:0]  ot0, ot1, ot2;

  exp_t q0[$], q1[$], q2[$];
  logic [63:0] hold [3];
  int stalls [3];
  int outs [3];
  bit acc_last [3];
  int cyc, n_assert, n_fail;

  always #5 clk = ~clk;

  mul_add_pipe #(.W(64), .STAGES(3), .TAG_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_x(x[0]), .in_y(y[0]), .in_z(z[0]), .in_c(cc[0]), .in_chain(chn[0]), .in_tag(tg[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .out_s(os0), .out_c(oc0), .out_tag(ot0),
    .busy(bsy[0])
  );

  mul_add_pipe #(.W(32), .STAGES(1), .TAG_W(8)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_x(x[1][31:0]), .in_y(y[1][31:0]), .in_z(z[1][31:0]), .in_c(cc[1][31:0]),
    .in_chain(chn[1]), .in_tag(tg[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .out_s(os1), .out_c(oc1), .out_tag(ot1),
    .busy(bsy[1])
  );

  mul_add_pipe #(.W(32), .STAGES(8), .TAG_W(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_x(x[2][31:0]), .in_y(y[2][31:0]), .in_z(z[2][31:0]), .in_c(cc[2][31:0]),
    .in_chain(chn[2]), .in_tag(tg[2]),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .out_s(os2), .out_c(oc2), .out_tag(ot2),
    .busy(bsy[2])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int stg(input int d);
    return (d == 0) ? 3 : ((d == 1) ? 1 : 8);
  endfunction

  function automatic logic [63:0] f_os(input int d);
    case (d)
      0:       return os0;
      1:       return {32'h0, os1};
      default: return {32'h0, os2};
    endcase
  endfunction

  function automatic logic [63:0] f_oc(input int d);
    case (d)
      0:       return oc0;
      1:       return {32'h0, oc1};
      default: return {32'h0, oc2};
    endcase
  endfunction

  function automatic logic [7:0] f_ot(input int d);
    case (d)
      0:       return ot0;
      1:       return ot1;
      default: return ot2;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int d);
    case (d)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qclear(input int d);
    case (d)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Reference: plain wide arithmetic, then split at the limb width.
  function automatic exp_t mk(input int d, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] e, input logic [63:0] k, input logic [7:0] t);
    exp_t        r;
    int          w;
    logic [127:0] full, m;
    w = (d == 0) ? 64 : 32;
    full = {64'h0, a} * {64'h0, b} + {64'h0, e} + {64'h0, k};
    m = (128'h1 << w) - 128'h1;
    r.r.s = 64'(full & m);
    r.r.c = 64'((full >> w) & m);
    r.tag = t;
    r.k = 0;
    r.snap = 0;
    return r;
  endfunction

  task automatic drive_rand();
    for (int d = 1; d < 3; d++) begin
      if (!vld[d] || acc_last[d]) begin
        if ($urandom_range(3) != 0) begin
          vld[d] = 1'b1;
          if ($urandom_range(15) == 0) begin
            x[d] = 64'hFFFF_FFFF; y[d] = 64'hFFFF_FFFF;
            z[d] = 64'hFFFF_FFFF; cc[d] = 64'hFFFF_FFFF;
          end else begin
            x[d] = {32'h0, $urandom()}; y[d] = {32'h0, $urandom()};
            z[d] = {32'h0, $urandom()}; cc[d] = {32'h0, $urandom()};
          end
          chn[d] = ($urandom_range(5) == 0);
          tg[d] = 8'($urandom());
        end else begin
          vld[d] = 1'b0;
        end
      end
      ordy[d] = ($urandom_range(4) != 0);
    end
  endtask

  // Compare every DUT with the model just before the edge, then advance the model.
  task automatic tick();
    exp_t f, e;
    bit ov, bz, rd, ac, dq;
    int el;
    logic [63:0] carry;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        chk($sformatf("d%0d_rst_ready", d), 64'(rdy[d]), 64'd0);
        chk($sformatf("d%0d_rst_ovalid", d), 64'(ovld[d]), 64'd0);
        chk($sformatf("d%0d_rst_busy", d), 64'(bsy[d]), 64'd0);
        qclear(d);
        hold[d] = '0;
        stalls[d] = 0;
        acc_last[d] = 1'b0;
      end else begin
        bz = (qsize(d) != 0);
        ov = 1'b0;
        if (bz) begin
          f = qfront(d);
          el = cyc - f.k - (stalls[d] - f.snap);
          ov = (el == stg(d));
        end
        rd = !(ov && !ordy[d]) && !(chn[d] && bz);
        chk($sformatf("d%0d_out_valid", d), 64'(ovld[d]), 64'(ov));
        chk($sformatf("d%0d_busy", d), 64'(bsy[d]), 64'(bz));
        chk($sformatf("d%0d_in_ready", d), 64'(rdy[d]), 64'(rd));
        if (ov) begin
          chk($sformatf("d%0d_out_s", d), f_os(d), f.r.s);
          chk($sformatf("d%0d_out_c", d), f_oc(d), f.r.c);
          chk($sformatf("d%0d_out_tag", d), 64'(f_ot(d)), 64'(f.tag));
        end
        ac = vld[d] && rd;
        dq = ov && ordy[d];
        if (ov && !ordy[d]) stalls[d]++;
        if (dq) begin
          qpop(d);
          hold[d] = f.r.c;
          outs[d]++;
        end
        if (ac) begin
          carry = chn[d] ? hold[d] : cc[d];
          e = mk(d, x[d], y[d], z[d], carry, tg[d]);
          e.k = cyc;
          e.snap = stalls[d];
          qpush(d, e);
        end
        acc_last[d] = ac;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    drive_rand();
  endtask

  task automatic send0(input logic [63:0] a, input logic [63:0] b, input logic [63:0] e,
                       input logic [63:0] k, input logic ch, input logic [7:0] t,
                       output int waited);
    x[0] = a; y[0] = b; z[0] = e; cc[0] = k; chn[0] = ch; tg[0] = t;
    vld[0] = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!acc_last[0] && waited < 50);
    chk("send_accepted", 64'(acc_last[0]), 64'd1);
    vld[0] = 1'b0;
    chn[0] = 1'b0;
  endtask

  initial begin
    int w;
    logic [63:0] saved_s, saved_c;
    n_assert = 0;
    n_fail = 0;
    cyc = 0;
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0; chn[d] = 1'b0; ordy[d] = 1'b1; tg[d] = '0;
      x[d] = '0; y[d] = '0; z[d] = '0; cc[d] = '0;
      hold[d] = '0; stalls[d] = 0; outs[d] = 0; acc_last[d] = 1'b0;
    end

    repeat (3) tick();
    chk("reset_out_s", os0, 64'd0);
    chk("reset_out_c", oc0, 64'd0);
    chk("reset_out_tag", 64'(ot0), 64'd0);
    chk("reset_in_ready", 64'(rdy[0]), 64'd0);
    rst_n = 1'b1;
    tick();

    // Max operands: result 2^128-1, visible exactly three cycles after accept.
    send0('1, '1, '1, '1, 1'b0, 8'hA5, w);
    chk("max_issue", 64'(w), 64'd1);
    tick();
    chk("max_not_early", 64'(ovld[0]), 64'd0);
    tick();
    chk("max_valid", 64'(ovld[0]), 64'd1);
    chk("max_s", os0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("max_c", oc0, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) tick();

    // Streaming: back-to-back accepts, s = 4i+4.
    for (int i = 0; i < 8; i++) begin
      send0(64'(i + 1), 64'd3, 64'(i), 64'd1, 1'b0, 8'(i), w);
      chk($sformatf("stream_issue_%0d", i), 64'(w), 64'd1);
    end
    repeat (6) tick();

    // Backpressure: fill, stall five cycles with a fourth beat waiting, then drain.
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send0(64'($urandom()), 64'($urandom()), 64'($urandom()), 64'($urandom()), 1'b0,
            8'(16 + i), w);
      chk($sformatf("bp_fill_%0d", i), 64'(w), 64'd1);
    end
    x[0] = 64'h1234; y[0] = 64'h10; z[0] = 64'h7; cc[0] = 64'h9; tg[0] = 8'd19;
    vld[0] = 1'b1;
    tick();
    saved_s = os0;
    saved_c = oc0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_blocked", 64'(acc_last[0]), 64'd0);
      chk("bp_hold_s", os0, saved_s);
      chk("bp_hold_c", oc0, saved_c);
    end
    ordy[0] = 1'b1;
    w = 0;
    do begin
      tick();
      w++;
    end while (!acc_last[0] && w < 50);
    chk("bp_release", 64'(acc_last[0]), 64'd1);
    vld[0] = 1'b0;
    repeat (8) tick();

    // Chain: A leaves c=2; B uses it instead of in_c and waits for A to drain.
    send0(64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0, 1'b0, 8'd40, w);
    send0(64'd1, 64'd1, 64'd5, 64'd99, 1'b1, 8'd41, w);
    chk("chain_spacing", 64'(w), 64'd4);
    tick();
    tick();
    chk("chain_valid", 64'(ovld[0]), 64'd1);
    chk("chain_s", os0, 64'd8);
    chk("chain_c", oc0, 64'd0);
    repeat (3) tick();

    // Reset with two beats in flight; the next chained beat sees a cleared carry.
    send0(64'hDEAD, 64'hBEEF, 64'd1, 64'd2, 1'b0, 8'd50, w);
    send0(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 64'd0, 1'b0, 8'd51, w);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ovalid", 64'(ovld[0]), 64'd0);
    chk("rst_mid_s", os0, 64'd0);
    chk("rst_mid_c", oc0, 64'd0);
    chk("rst_mid_tag", 64'(ot0), 64'd0);
    chk("rst_mid_ready", 64'(rdy[0]), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_no_stale", 64'(ovld[0]), 64'd0);
    send0(64'd3, 64'd5, 64'd1, 64'd77, 1'b1, 8'd52, w);
    tick();
    tick();
    chk("rst_chain_valid", 64'(ovld[0]), 64'd1);
    chk("rst_chain_s", os0, 64'd16);
    chk("rst_chain_c", oc0, 64'd0);

    // Random traffic on the STAGES=1 and STAGES=8 instances.
    repeat (800) tick();
    chk("sweep_s1_traffic", 64'(outs[1] > 100), 64'd1);
    chk("sweep_s8_traffic", 64'(outs[2] > 50), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
